// File: rtl/dlx_seq_alu.sv
// rtl/dlx_seq_alu.sv - multi-cycle DLX ALU with start/busy/done handshake and shift-add multiply.
// Restoring divider present only when DLX_SEQ_ALU_DIV_EN is defined.
module dlx_seq_alu #(
  parameter int WIDTH = 32,
  parameter int IMM_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] s1,
  input  logic [WIDTH-1:0] s2,
  input  logic [4:0]       ALUop,
  input  logic [2:0]       s2op,
  output logic [WIDTH-1:0] ALUout,
  output logic             Zflag,
  output logic             err,
  output logic             busy,
  output logic             done
);
  localparam int SHW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;
  state_t state, state_nxt;

  logic [WIDTH-1:0] op2, s_res, s1_mag, op2_mag;
  logic [WIDTH-1:0] acc, mcand, mplier;
  logic [WIDTH-1:0] mul_nxt, mul_fin;
  logic [SHW-1:0]   shamt, cnt;
  logic             s_err, neg, accept, is_mul, is_div, div_zero, single_fire, sgn_op, last_iter;

  always_comb begin
    case (s2op)
      3'b001:  op2 = '0;
      3'b010:  op2 = {{(WIDTH-IMM_W){s2[IMM_W-1]}}, s2[IMM_W-1:0]};
      3'b011:  op2 = {{(WIDTH-IMM_W){1'b0}}, s2[IMM_W-1:0]};
      3'b100:  op2 = {{(WIDTH-IMM_W){1'b0}}, s2[IMM_W-1:0]} << IMM_W;
      default: op2 = s2;
    endcase
  end

  assign shamt  = op2[SHW-1:0];
  assign accept = start && (state == S_IDLE);
  assign is_mul = (ALUop == 5'b01110) || (ALUop == 5'b01111);
`ifdef DLX_SEQ_ALU_DIV_EN
  assign is_div = (ALUop == 5'b10010) || (ALUop == 5'b10011);
`else
  assign is_div = 1'b0;
`endif
  assign div_zero    = is_div && (op2 == '0);
  assign single_fire = accept && !is_mul && !(is_div && !div_zero);

  // Signed mul/div run on magnitudes; ALUop bit 0 marks the signed variants.
  assign sgn_op  = ALUop[0];
  assign s1_mag  = (sgn_op && s1[WIDTH-1])  ? -s1  : s1;
  assign op2_mag = (sgn_op && op2[WIDTH-1]) ? -op2 : op2;

  always_comb begin
    s_res = '0;
    s_err = 1'b0;
    case (ALUop)
      5'b00000: s_res = s1 + op2;
      5'b00001: s_res = s1 - op2;
      5'b00010: s_res = s1 & op2;
      5'b00011: s_res = s1 | op2;
      5'b00100: s_res = s1 ^ op2;
      5'b00101: s_res = s1 << shamt;
      5'b00110: s_res = s1 >> shamt;
      5'b00111: s_res = $signed(s1) >>> shamt;
      5'b01000: s_res = {{(WIDTH-1){1'b0}}, s1 == op2};
      5'b01001: s_res = {{(WIDTH-1){1'b0}}, s1 != op2};
      5'b01010: s_res = {{(WIDTH-1){1'b0}}, $signed(s1) <  $signed(op2)};
      5'b01011: s_res = {{(WIDTH-1){1'b0}}, $signed(s1) >  $signed(op2)};
      5'b01100: s_res = {{(WIDTH-1){1'b0}}, $signed(s1) <= $signed(op2)};
      5'b01101: s_res = {{(WIDTH-1){1'b0}}, $signed(s1) >= $signed(op2)};
      5'b01110, 5'b01111: s_res = '0;
      5'b10000: s_res = s1 - op2;
`ifdef DLX_SEQ_ALU_DIV_EN
      // Only reached as a single-cycle op when the divisor is zero.
      5'b10010, 5'b10011: begin
        s_res = '1;
        s_err = 1'b1;
      end
`endif
      default: s_err = 1'b1;
    endcase
  end

  assign mul_nxt = acc + (mplier[0] ? mcand : '0);
  assign mul_fin = neg ? -mul_nxt : mul_nxt;

`ifdef DLX_SEQ_ALU_DIV_EN
  logic [WIDTH:0]   rem_sh, diff;
  logic [WIDTH-1:0] rem_nxt, quo_nxt, div_fin;
  always_comb begin
    rem_sh = {acc, mplier[WIDTH-1]};
    diff   = rem_sh - {1'b0, mcand};
    if (!diff[WIDTH]) begin
      rem_nxt = diff[WIDTH-1:0];
      quo_nxt = {mplier[WIDTH-2:0], 1'b1};
    end else begin
      rem_nxt = rem_sh[WIDTH-1:0];
      quo_nxt = {mplier[WIDTH-2:0], 1'b0};
    end
    div_fin = neg ? -quo_nxt : quo_nxt;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept && is_mul)                     state_nxt = S_MUL;
        else if (accept && is_div && !div_zero)   state_nxt = S_DIV;
      end
      S_MUL, S_DIV: if (cnt == '0) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != S_IDLE);
    last_iter = busy && (cnt == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ALUout <= '0;
      Zflag  <= 1'b1;
      err    <= 1'b0;
      done   <= 1'b0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      neg    <= 1'b0;
      cnt    <= '0;
    end else begin
      done <= 1'b0;
      if (single_fire) begin
        ALUout <= s_res;
        Zflag  <= (s_res == '0);
        err    <= s_err;
        done   <= 1'b1;
      end else if (accept) begin
        // Multiply: mcand/mplier. Divide: mcand=divisor, mplier=dividend shifting into quotient.
        acc    <= '0;
        mcand  <= is_mul ? s1_mag  : op2_mag;
        mplier <= is_mul ? op2_mag : s1_mag;
        neg    <= sgn_op && (s1[WIDTH-1] ^ op2[WIDTH-1]);
        cnt    <= SHW'(WIDTH-1);
      end
      if (state == S_MUL) begin
        acc    <= mul_nxt;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt - 1'b1;
        if (last_iter) begin
          ALUout <= mul_fin;
          Zflag  <= (mul_fin == '0);
          err    <= 1'b0;
          done   <= 1'b1;
        end
      end
`ifdef DLX_SEQ_ALU_DIV_EN
      if (state == S_DIV) begin
        acc    <= rem_nxt;
        mplier <= quo_nxt;
        cnt    <= cnt - 1'b1;
        if (last_iter) begin
          ALUout <= div_fin;
          Zflag  <= (div_fin == '0);
          err    <= 1'b0;
          done   <= 1'b1;
        end
      end
`endif
    end
  end
endmodule
